// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and the RAW readiness rule for the register scoreboard.
// SCOREBOARD_FWD_EN: a counter at 1 is treated as ready because the bypass delivers the result next cycle.
package reg_scoreboard_pkg;

  localparam int ZERO_REG     = 0;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_RD_PORTS = 2;
  localparam int DEF_LAT_W    = 3;

  function automatic logic not_ready(input int unsigned cnt);
`ifdef SCOREBOARD_FWD_EN
    return cnt > 1;
`else
    return cnt != 0;
`endif
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/read/writeback bundle between the decode stage and the register scoreboard.
interface reg_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2,
  parameter int LAT_W    = 3
);

  logic                         issue_valid;
  logic                         wr_en;
  logic [ADDR_W-1:0]            wr_addr;
  logic [LAT_W-1:0]             wr_lat;
  logic [RD_PORTS-1:0]          rd_en;
  logic [RD_PORTS*ADDR_W-1:0]   rd_addr;
  logic                         wb_en;
  logic [ADDR_W-1:0]            wb_addr;
  logic                         flush;
  logic                         hazard;
  logic [RD_PORTS-1:0]          hazard_port;
  logic                         issue_fire;
  logic [NUM_REGS-1:0]          busy_vec;

  modport master (
    output issue_valid, wr_en, wr_addr, wr_lat, rd_en, rd_addr, wb_en, wb_addr, flush,
    input  hazard, hazard_port, issue_fire, busy_vec
  );

  modport slave (
    input  issue_valid, wr_en, wr_addr, wr_lat, rd_en, rd_addr, wb_en, wb_addr, flush,
    output hazard, hazard_port, issue_fire, busy_vec
  );

endinterface

// File: rtl/reg_sb_entry.sv
// One register's pending-latency counter: flush, then load, then clear, then decrement.
module reg_sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             clear,
  input  logic [LAT_W-1:0] lat,
  output logic [LAT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= lat;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// GPR scoreboard: per-register latency counters, RAW/WAW stall detection and issue acceptance.
// SCOREBOARD_FWD_EN (via the package) relaxes RAW readiness only; WAW always needs an idle counter.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RD_PORTS = DEF_RD_PORTS,
  parameter int LAT_W    = DEF_LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_scoreboard_if.slave  sb
);

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
  logic [NUM_REGS-1:1]            load_vec;
  logic [NUM_REGS-1:1]            clear_vec;
  logic [NUM_REGS-1:0]            busy;
  logic [RD_PORTS-1:0]            raw_vec;
  logic                           waw;
  logic                           hazard_int;
  logic                           fire_int;

  // Addresses beyond the implemented file read as idle.
  function automatic logic [LAT_W-1:0] cnt_of(input logic [ADDR_W-1:0] addr);
    if (int'(addr) < NUM_REGS) return cnt[addr];
    return '0;
  endfunction

  always_comb begin
    raw_vec = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      if (sb.rd_en[k] && sb.rd_addr[k*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))
        raw_vec[k] = not_ready(32'(cnt_of(sb.rd_addr[k*ADDR_W +: ADDR_W])));
    end
  end

  always_comb begin
    waw        = sb.issue_valid && sb.wr_en && (sb.wr_addr != ADDR_W'(ZERO_REG)) &&
                 (cnt_of(sb.wr_addr) != '0);
    hazard_int = sb.issue_valid && ((|raw_vec) || waw) && !sb.flush;
    fire_int   = sb.issue_valid && !hazard_int && !sb.flush;
  end

  always_comb begin
    load_vec  = '0;
    clear_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      load_vec[r]  = fire_int && sb.wr_en && (int'(sb.wr_addr) == r);
      clear_vec[r] = sb.wb_en && (int'(sb.wb_addr) == r);
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) busy[r] = (cnt[r] != '0);
  end

  assign cnt[ZERO_REG] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    reg_sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (sb.flush),
      .load  (load_vec[r]),
      .clear (clear_vec[r]),
      .lat   (sb.wr_lat),
      .cnt   (cnt[r])
    );
  end

  assign sb.hazard      = hazard_int;
  assign sb.hazard_port = raw_vec;
  assign sb.issue_fire  = fire_int;
  assign sb.busy_vec    = busy;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scenario and randomized checks of reg_scoreboard against a cycles-remaining model of each register.
module tb_reg_scoreboard;

  localparam int NR    = 32;
  localparam int AW    = 5;
  localparam int RP    = 2;
  localparam int LW    = 3;
  localparam int RAW_W = RP * AW;
`ifdef SCOREBOARD_FWD_EN
  localparam int EXP_STALL = 2;
`else
  localparam int EXP_STALL = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.NUM_REGS(NR), .ADDR_W(AW), .RD_PORTS(RP), .LAT_W(LW)) sb ();

  reg_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .RD_PORTS(RP), .LAT_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb)
  );

  // Model: cycles until each register's pending result is readable.
  int              remain [NR];
  logic            exp_hazard;
  logic [RP-1:0]   exp_hport;
  logic            exp_fire;
  logic [NR-1:0]   exp_busy;

  function automatic logic still_pending(input int left);
`ifdef SCOREBOARD_FWD_EN
    return left >= 2;
`else
    return left >= 1;
`endif
  endfunction

  task automatic predict();
    int  a;
    logic w;
    exp_hport = '0;
    for (int k = 0; k < RP; k++) begin
      a = int'(sb.rd_addr[k*AW +: AW]);
      if (sb.rd_en[k] && a != 0 && a < NR && still_pending(remain[a])) exp_hport[k] = 1'b1;
    end
    a = int'(sb.wr_addr);
    w = sb.issue_valid && sb.wr_en && a != 0 && a < NR && remain[a] > 0;
    exp_hazard = sb.issue_valid && !sb.flush && ((exp_hport != '0) || w);
    exp_fire   = sb.issue_valid && !sb.flush && !exp_hazard;
    for (int r = 0; r < NR; r++) exp_busy[r] = (remain[r] > 0);
  endtask

  task automatic settle();
    #4;
    predict();
  endtask

  task automatic advance();
    predict();
    @(posedge clk);
    for (int r = 0; r < NR; r++) begin
      if (!rst_n || sb.flush || r == 0) remain[r] = 0;
      else if (exp_fire && sb.wr_en && int'(sb.wr_addr) == r) remain[r] = int'(sb.wr_lat);
      else if (sb.wb_en && int'(sb.wb_addr) == r) remain[r] = 0;
      else if (remain[r] > 0) remain[r] = remain[r] - 1;
    end
    #1;
  endtask

  task automatic idle();
    sb.issue_valid = 1'b0;
    sb.wr_en       = 1'b0;
    sb.wr_addr     = '0;
    sb.wr_lat      = '0;
    sb.rd_en       = '0;
    sb.rd_addr     = '0;
    sb.wb_en       = 1'b0;
    sb.wb_addr     = '0;
    sb.flush       = 1'b0;
  endtask

  task automatic issue_write(input int addr, input int lat);
    idle();
    sb.issue_valid = 1'b1;
    sb.wr_en       = 1'b1;
    sb.wr_addr     = AW'(addr);
    sb.wr_lat      = LW'(lat);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    advance();
    advance();
    rst_n = 1'b1;
    settle();
    total++;
    if (sb.busy_vec !== '0) begin bad++; $display("FAIL reset_busy: got %h want 0", sb.busy_vec); end
    total++;
    if (sb.hazard !== 1'b0 || sb.hazard_port !== '0) begin
      bad++; $display("FAIL reset_hazard: got %b/%b want 0/0", sb.hazard, sb.hazard_port);
    end
    total++;
    if (sb.issue_fire !== 1'b0) begin bad++; $display("FAIL reset_fire: got %b want 0", sb.issue_fire); end
    advance();
  endtask

  task automatic test_raw_latency();
    int stall = 0;
    bit done = 0;
    issue_write(5, 3);
    settle();
    total++;
    if (sb.issue_fire !== 1'b1) begin bad++; $display("FAIL raw_first_fire: got %b want 1", sb.issue_fire); end
    advance();
    idle();
    sb.issue_valid = 1'b1;
    sb.rd_en       = 2'b11;
    sb.rd_addr     = {AW'(5), AW'(5)};
    for (int i = 0; i < 8 && !done; i++) begin
      settle();
      total++;
      if (sb.hazard !== exp_hazard || sb.hazard_port !== exp_hport) begin
        bad++; $display("FAIL raw_step%0d: got %b/%b want %b/%b", i, sb.hazard, sb.hazard_port, exp_hazard, exp_hport);
      end
      if (sb.issue_fire === 1'b1) done = 1;
      else stall++;
      advance();
    end
    total++;
    if (!done || stall != EXP_STALL) begin
      bad++; $display("FAIL raw_stall_cycles: got %0d (fired=%0d) want %0d", stall, done, EXP_STALL);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    issue_write(0, 7);
    settle();
    total++;
    if (sb.issue_fire !== 1'b1) begin bad++; $display("FAIL zero_fire: got %b want 1", sb.issue_fire); end
    advance();
    idle();
    sb.issue_valid = 1'b1;
    sb.rd_en       = 2'b01;
    sb.rd_addr     = '0;
    settle();
    total++;
    if (sb.busy_vec[0] !== 1'b0 || sb.hazard !== 1'b0 || sb.issue_fire !== 1'b1) begin
      bad++; $display("FAIL zero_read: got busy0=%b hazard=%b fire=%b want 0 0 1", sb.busy_vec[0], sb.hazard, sb.issue_fire);
    end
    advance();
    idle();
  endtask

  task automatic test_wb_priority();
    int busy_cycles = 0;
    issue_write(8, 4);
    advance();
    idle();
    sb.wb_en   = 1'b1;
    sb.wb_addr = AW'(8);
    settle();
    total++;
    if (sb.busy_vec[8] !== 1'b1) begin bad++; $display("FAIL wb_busy_before: got %b want 1", sb.busy_vec[8]); end
    advance();
    idle();
    settle();
    total++;
    if (sb.busy_vec[8] !== 1'b0) begin bad++; $display("FAIL wb_clear: got %b want 0", sb.busy_vec[8]); end
    issue_write(8, 2);
    sb.wb_en   = 1'b1;
    sb.wb_addr = AW'(8);
    settle();
    total++;
    if (sb.issue_fire !== 1'b1) begin bad++; $display("FAIL wb_issue_fire: got %b want 1", sb.issue_fire); end
    advance();
    idle();
    for (int i = 0; i < 5; i++) begin
      settle();
      if (sb.busy_vec[8] === 1'b1) busy_cycles++;
      advance();
    end
    total++;
    if (busy_cycles != 2) begin bad++; $display("FAIL wb_issue_priority: got %0d busy cycles want 2", busy_cycles); end
  endtask

  task automatic test_waw();
    issue_write(3, 5);
    advance();
    issue_write(3, 1);
    settle();
    total++;
    if (sb.hazard !== 1'b1 || sb.issue_fire !== 1'b0 || sb.hazard_port !== '0) begin
      bad++; $display("FAIL waw: got hazard=%b fire=%b port=%b want 1 0 00", sb.hazard, sb.issue_fire, sb.hazard_port);
    end
    advance();
    idle();
  endtask

  task automatic test_flush();
    issue_write(4, 6);
    advance();
    issue_write(9, 7);
    advance();
    issue_write(12, 3);
    sb.flush = 1'b1;
    settle();
    total++;
    if (sb.issue_fire !== 1'b0 || sb.hazard !== 1'b0 || sb.busy_vec[4] !== 1'b1 || sb.busy_vec[9] !== 1'b1) begin
      bad++; $display("FAIL flush_cycle: got fire=%b hazard=%b b4=%b b9=%b want 0 0 1 1", sb.issue_fire, sb.hazard, sb.busy_vec[4], sb.busy_vec[9]);
    end
    advance();
    idle();
    settle();
    total++;
    if (sb.busy_vec !== '0) begin bad++; $display("FAIL flush_clear: got %h want 0", sb.busy_vec); end
    advance();
  endtask

  task automatic test_reset_mid();
    issue_write(2, 5);
    advance();
    idle();
    rst_n = 1'b0;
    settle();
    total++;
    if (sb.busy_vec[2] !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b want 1", sb.busy_vec[2]); end
    advance();
    rst_n          = 1'b1;
    sb.issue_valid = 1'b1;
    sb.rd_en       = 2'b11;
    sb.rd_addr     = {AW'(2), AW'(2)};
    settle();
    total++;
    if (sb.busy_vec !== '0 || sb.hazard !== 1'b0 || sb.hazard_port !== '0 || sb.issue_fire !== 1'b1) begin
      bad++; $display("FAIL rstmid_after: got busy=%h hazard=%b port=%b fire=%b want 0 0 00 1", sb.busy_vec, sb.hazard, sb.hazard_port, sb.issue_fire);
    end
    advance();
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n          = ($urandom_range(0, 99) != 0);
      sb.issue_valid = ($urandom_range(0, 9) < 8);
      sb.wr_en       = ($urandom_range(0, 9) < 7);
      sb.wr_addr     = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      sb.wr_lat      = LW'($urandom);
      sb.rd_en       = RP'($urandom);
      sb.rd_addr     = {AW'($urandom_range(0, 7)), AW'($urandom)};
      sb.wb_en       = ($urandom_range(0, 3) == 0);
      sb.wb_addr     = AW'($urandom_range(0, 7));
      sb.flush       = ($urandom_range(0, 29) == 0);
      settle();
      total++;
      if (sb.hazard !== exp_hazard || sb.hazard_port !== exp_hport) begin
        bad++; $display("FAIL rand_hazard@%0d: got %b/%b want %b/%b", i, sb.hazard, sb.hazard_port, exp_hazard, exp_hport);
      end
      total++;
      if (sb.issue_fire !== exp_fire) begin
        bad++; $display("FAIL rand_fire@%0d: got %b want %b", i, sb.issue_fire, exp_fire);
      end
      total++;
      if (sb.busy_vec !== exp_busy) begin
        bad++; $display("FAIL rand_busy@%0d: got %h want %h", i, sb.busy_vec, exp_busy);
      end
      advance();
    end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    for (int r = 0; r < NR; r++) remain[r] = 0;
    idle();
    test_reset();
    test_raw_latency();
    test_zero_reg();
    test_wb_priority();
    test_waw();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural GPRs.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have parameter RD_PORTS, default 2, number of source-operand read channels.
REQ-004 SHALL have parameter LAT_W, default 3, width of the per-register pending-latency counter.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port issue_valid  input  1  decoded instruction presented for issue.
REQ-008 SHALL have port wr_en  input  1  instruction writes a GPR.
REQ-009 SHALL have port wr_addr  input  ADDR_W  destination register.
REQ-010 SHALL have port wr_lat  input  LAT_W  cycles until the result is readable; 0 means not tracked.
REQ-011 SHALL have port rd_en  input  RD_PORTS  per-channel source-read enable.
REQ-012 SHALL have port rd_addr  input  RD_PORTS*ADDR_W  packed source addresses; channel k at bits [k*ADDR_W +: ADDR_W].
REQ-013 SHALL have port wb_en  input  1  early writeback; clears pending state of wb_addr.
REQ-014 SHALL have port wb_addr  input  ADDR_W  writeback register.
REQ-015 SHALL have port flush  input  1  pipeline flush.
REQ-016 SHALL have port hazard  output  1  issue must stall this cycle.
REQ-017 SHALL have port hazard_port  output  RD_PORTS  per-channel RAW hazard flags.
REQ-018 SHALL have port issue_fire  output  1  instruction accepted this cycle.
REQ-019 SHALL have port busy_vec  output  NUM_REGS  bit r set when cnt[r] != 0.

Function
REQ-020 SHALL keep one LAT_W-bit counter cnt[r] per register; register 0 is never tracked and its counter is constantly 0.
REQ-021 SHALL set hazard_port[k] = rd_en[k] && rd_addr_k != 0 && not-ready(cnt[rd_addr_k]), combinational from current state.
REQ-022 SHALL flag a WAW hazard when issue_valid && wr_en && wr_addr != 0 && cnt[wr_addr] != 0.
REQ-023 SHALL drive hazard = issue_valid && (OR of hazard_port || WAW) && !flush.
REQ-024 SHALL drive issue_fire = issue_valid && !hazard && !flush.
REQ-025 SHALL, per cycle per register, apply the first matching rule: flush -> 0; issue_fire && wr_en && wr_addr == r && r != 0 -> wr_lat; wb_en && wb_addr == r -> 0; cnt != 0 -> cnt - 1; else hold.
REQ-026 SHALL give issue priority over same-cycle writeback to the same register.
REQ-027 SHALL treat wr_lat = 0 as an immediate result: no counter load, no later hazard.
REQ-028 SHALL allow back-to-back issue at one per cycle when no hazard exists.
REQ-029 SHALL treat out-of-range addresses (>= NUM_REGS) as never busy and ignore writes to them.

Reset
REQ-030 SHALL clear all counters when rst_n is low at a rising clk edge; hazard, hazard_port, issue_fire and busy_vec read 0 from the following cycle.
REQ-031 SHALL give reset priority over flush, issue and writeback; pending state is discarded mid-operation.

Configuration
REQ-032 SHALL use macro SCOREBOARD_FWD_EN.
REQ-033 SHALL, when SCOREBOARD_FWD_EN is defined, treat cnt == 1 as ready (bypass available next cycle); not-ready means cnt > 1.
REQ-034 SHALL, when SCOREBOARD_FWD_EN is undefined, define not-ready as cnt != 0.
REQ-035 SHALL apply the macro to RAW detection only; WAW detection is unaffected.

Structure
REQ-036 SHALL take REG_ADDR_BUS width and the zero-register index from the shared bus.v header; no new constants there.
REQ-037 SHALL use one sub-module reg_sb_entry (counter plus load/clear/decrement priority), instantiated NUM_REGS-1 times in a generate loop.

Verification
REQ-038 SHALL verify: issue wr $5 lat 3, next cycle read $5 -> hazard=1 for 2 cycles (FWD on) / 3 cycles (FWD off), then issue_fire=1.
REQ-039 SHALL verify: issue wr $0 lat 7, then read $0 -> busy_vec[0]=0, hazard=0.
REQ-040 SHALL verify: $8 busy cnt 4, wb_en $8 -> cnt 0 next cycle; same cycle with issue wr $8 lat 2 -> cnt 2.
REQ-041 SHALL verify: $3 busy, new issue writing $3 with sources clear -> hazard=1 (WAW), issue_fire=0.
REQ-042 SHALL verify: $4,$9 busy, flush=1 -> busy_vec=0 next cycle, issue_fire=0 during flush.
REQ-043 SHALL verify: rst_n=0 with $2 cnt 5 -> busy_vec=0 next cycle, reads of $2 hazard-free.
